// File: rtl/dm_port_pkg.sv
// Shared types for the data-memory responder: size codes, FSM states and
// the alignment rule applied to incoming requests.
package dm_port_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    RESP,
    ERR
  } state_t;

  // Reserved size code 3 is treated as an error, like a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_port_if.sv
// Request/response bundle between the core's load/store sequencer (master)
// and the data-memory responder (slave).
interface dm_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wr, req_size, req_sign, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_sign, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_port_lane.sv
// Little-endian lane steering: extracts and extends load data from a RAM
// word, and merges sub-word store data into a RAM word.
module dm_lane
  import dm_port_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = word[{off, 3'b000} +: 8];
    lane_h    = off[1] ? word[31:16] : word[15:0];
    load_data = word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign & lane_b[7]}}, lane_b};
        merged    = word;
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{sign & lane_h[15]}}, lane_h};
        merged    = word;
        merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_port.sv
// Data-memory responder for the multicycle MIPS core: word/half/byte loads
// and stores, sub-word stores via read-modify-write, alignment errors.
module dm_port
  import dm_port_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input logic     clk,
  input logic     rst,
  dm_port_if.slave bus
);

  state_t state, state_nxt;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       ram_q;
  logic [31:0]       load_data;
  logic [31:0]       merged;
  logic [31:0]       wr_word;
  logic              accept;
  logic              req_bad;

  logic              cap_wr;
  logic [1:0]        cap_size;
  logic              cap_sign;
  logic [1:0]        cap_off;
  logic [ADDR_W-1:0] cap_idx;
  logic [31:0]       cap_wdata;

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid & bus.req_ready;
  assign req_bad       = misaligned(bus.req_size, bus.req_addr[1:0]);
  assign wr_word       = (state == MERGE) ? merged : cap_wdata;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                              state_nxt = ERR;
          else if (bus.req_wr && bus.req_size == SZ_WORD) state_nxt = WRITE;
          else                                      state_nxt = READ;
        end
      end
      READ:    state_nxt = cap_wr ? MERGE : RESP;
      MERGE:   state_nxt = RESP;
      WRITE:   state_nxt = RESP;
      ERR:     state_nxt = IDLE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cap_wr         <= 1'b0;
      cap_size       <= '0;
      cap_sign       <= 1'b0;
      cap_off        <= '0;
      cap_idx        <= '0;
      cap_wdata      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_wr    <= bus.req_wr;
        cap_size  <= bus.req_size;
        cap_sign  <= bus.req_sign;
        cap_off   <= bus.req_addr[1:0];
        cap_idx   <= bus.req_addr[ADDR_W+1:2];
        cap_wdata <= bus.req_wdata;
      end
      // Response registers load on entry to ERR/RESP so resp_valid is high
      // exactly while the FSM sits in one of those states.
      bus.resp_valid <= (state_nxt == RESP) || (state_nxt == ERR);
      if (state_nxt == ERR) begin
        bus.resp_err   <= 1'b1;
        bus.resp_rdata <= '0;
      end else if (state_nxt == RESP) begin
        bus.resp_err   <= 1'b0;
        bus.resp_rdata <= cap_wr ? '0 : load_data;
      end
    end
  end

  // The read is launched on the acceptance edge, so the word is on ram_q
  // throughout READ and stays there through MERGE.
  always_ff @(posedge clk) begin
    if (accept)
      ram_q <= mem[bus.req_addr[ADDR_W+1:2]];
    if (rst && (state == WRITE || state == MERGE))
      mem[cap_idx] <= wr_word;
  end

  dm_lane u_lane (
    .word      (ram_q),
    .off       (cap_off),
    .size      (cap_size),
    .sign      (cap_sign),
    .wdata     (cap_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

endmodule

// File: tb/tb_dm_port.sv
// Directed, table-driven bench for dm_port plus hand-written handshake and
// mid-operation reset sequences.
module tb_dm_port;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dm_port_if bus ();

  dm_port #(.ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[22];
  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sign,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int lat, input logic err, input logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic wr, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_wr    = wr;
    bus.req_size  = size;
    bus.req_sign  = sign;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
  endtask

  // Issue one request, measure response latency in cycles after acceptance,
  // then confirm the pulse is one cycle long and the block is idle again.
  task automatic run_req(input vec_t v, input string name);
    int lat;
    int waited;
    @(negedge clk);
    drive(v.wr, v.size, v.sign, v.addr, v.wdata);
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({name, ".ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.resp_valid !== 1'b1) lat = 0;
    chk({name, ".lat"},   lat, v.lat);
    chk({name, ".err"},   {31'd0, bus.resp_err}, {31'd0, v.err});
    chk({name, ".rdata"}, bus.resp_rdata, v.rdata);
    @(posedge clk);
    #1;
    chk({name, ".after"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
  endtask

  initial begin : main
    int n;
    logic [31:0] rd_trace;
    bus.req_valid = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    bus.req_valid = 1'b0;

    vecs[0]  = mk(1, 2'd2, 0, 32'h10,   32'hDEADBEEF, 2, 0, 32'h0);
    vecs[1]  = mk(0, 2'd2, 0, 32'h10,   32'h0,        2, 0, 32'hDEADBEEF);
    vecs[2]  = mk(0, 2'd0, 1, 32'h13,   32'h0,        2, 0, 32'hFFFFFFDE);
    vecs[3]  = mk(0, 2'd0, 0, 32'h13,   32'h0,        2, 0, 32'h000000DE);
    vecs[4]  = mk(0, 2'd1, 1, 32'h12,   32'h0,        2, 0, 32'hFFFFDEAD);
    vecs[5]  = mk(0, 2'd1, 0, 32'h10,   32'h0,        2, 0, 32'h0000BEEF);
    vecs[6]  = mk(0, 2'd0, 1, 32'h10,   32'h0,        2, 0, 32'hFFFFFFEF);
    vecs[7]  = mk(1, 2'd0, 0, 32'h11,   32'h12345655, 3, 0, 32'h0);
    vecs[8]  = mk(0, 2'd2, 0, 32'h10,   32'h0,        2, 0, 32'hDEAD55EF);
    vecs[9]  = mk(1, 2'd1, 0, 32'h12,   32'h0000CAFE, 3, 0, 32'h0);
    vecs[10] = mk(0, 2'd2, 0, 32'h10,   32'h0,        2, 0, 32'hCAFE55EF);
    vecs[11] = mk(0, 2'd2, 0, 32'h12,   32'h0,        1, 1, 32'h0);
    vecs[12] = mk(1, 2'd1, 0, 32'h13,   32'h0000FFFF, 1, 1, 32'h0);
    vecs[13] = mk(0, 2'd2, 0, 32'h10,   32'h0,        2, 0, 32'hCAFE55EF);
    vecs[14] = mk(0, 2'd3, 0, 32'h10,   32'h0,        1, 1, 32'h0);
    vecs[15] = mk(1, 2'd2, 0, 32'h1010, 32'h11223344, 2, 0, 32'h0);
    vecs[16] = mk(0, 2'd2, 0, 32'h10,   32'h0,        2, 0, 32'h11223344);
    vecs[17] = mk(0, 2'd0, 1, 32'h13,   32'h0,        2, 0, 32'h00000011);
    vecs[18] = mk(0, 2'd1, 1, 32'h12,   32'h0,        2, 0, 32'h00001122);
    vecs[19] = mk(1, 2'd0, 0, 32'h13,   32'h00000080, 3, 0, 32'h0);
    vecs[20] = mk(0, 2'd0, 1, 32'h13,   32'h0,        2, 0, 32'hFFFFFF80);
    vecs[21] = mk(0, 2'd2, 1, 32'h10,   32'h0,        2, 0, 32'h80223344);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.state", {bus.req_ready, bus.resp_valid, bus.resp_err, 29'd0}, 32'h80000000);
    chk("reset.rdata", bus.resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 22; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Held request across an sb: block busy for three cycles, re-accepts
    // on the edge after the idle cycle that follows resp_valid.
    @(negedge clk);
    drive(1'b1, 2'd0, 1'b0, 32'h10, 32'h00000066);
    @(posedge clk);
    rd_trace = '0;
    for (int c = 0; c < 7; c++) begin
      #1;
      rd_trace[c]      = bus.req_ready;
      rd_trace[8 + c]  = bus.resp_valid;
      @(posedge clk);
    end
    #1;
    bus.req_valid = 1'b0;
    // ready after E0..E6: 0,0,0,1,0,0,0 ; valid: 0,0,1,0,0,0,1
    chk("hold.ready", {24'd0, rd_trace[7:0]}, 32'h00000008);
    chk("hold.valid", {24'd0, rd_trace[15:8]}, 32'h00000044);
    repeat (2) @(posedge clk);
    run_req(mk(0, 2'd2, 0, 32'h10, 32'h0, 2, 0, 32'h80223366), "hold.readback");

    // Reset asserted for the MERGE edge of sb 0x10: no write, no response.
    @(negedge clk);
    drive(1'b1, 2'd0, 1'b0, 32'h10, 32'h000000AA);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rstmid.idle", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid === 1'b1) n++;
    end
    chk("rstmid.noresp", n, 0);
    run_req(mk(0, 2'd2, 0, 32'h10, 32'h0, 2, 0, 32'h80223366), "rstmid.readback");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule

// File: doc/dm_port.md
Name: dm_port

Overview:
Data-memory responder for the multicycle MIPS core. The core's load/store state sequence is the initiator; this block holds the data RAM and serves word, halfword and byte accesses: lw, lh, lhu, lb, lbu, sw, sh, sb. Sub-word stores use an internal read-modify-write. Misaligned accesses are reported back to the core as an address error.

Parameters:
ADDR_W, 10, word-address width; RAM holds 2**ADDR_W 32-bit words (byte address bits [ADDR_W+1:2] used).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
req_valid  in  1  access request present
req_ready  out  1  block idle and accepting; a request is taken when req_valid & req_ready
req_wr  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as error)
req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle pulse, access complete
resp_rdata  out  32  load result, extended; 0 for stores and errors
resp_err  out  1  valid with resp_valid; 1 = misaligned or reserved size, no RAM write done

Behaviour:
- Reset (rst == 0 at a clock edge) has priority over everything: state <= IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, and the captured request is cleared. RAM contents are not reset.
- Reset mid-operation aborts the access with no response. If reset is low in the WRITE or MERGE cycle, the RAM is not written.
- Lanes are little-endian: byte offset addr[1:0] = k occupies bits [8k+7:8k]; halfword offset addr[1] selects [15:0] or [31:16].
- Alignment error when any of these holds: size 1 with addr[0] = 1; size 2 with addr[1:0] != 0; size 3.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo RAM size. This is not an error.
- RAM has a synchronous read: the word read in one cycle is available in the next cycle.
- req_ready = 1 only in IDLE. The request fields are captured on acceptance and are don't-care afterwards.
- The response has no backpressure; the initiator must be waiting.
- States and transitions:
  - IDLE -> ERR on an accepted error request.
  - IDLE -> READ on an accepted load or sub-word store.
  - IDLE -> WRITE on an accepted word store.
  - IDLE stays IDLE otherwise.
  - READ (RAM read issued) -> RESP for a load; READ -> MERGE for sb/sh.
  - MERGE: replace the addressed lane(s) of the read word with req_wdata and write the RAM -> RESP.
  - WRITE: write req_wdata to the RAM -> RESP.
  - ERR -> IDLE.
  - RESP -> IDLE.
- Response timing: resp_valid is registered and asserted for exactly one cycle, counted in cycles after the acceptance edge.
  - Error: resp_err = 1 and rdata = 0, 1 cycle after acceptance, asserted while in ERR.
  - Load: 2 cycles, asserted while in RESP. rdata is the extracted lane, sign- or zero-extended per req_sign; for a word load req_sign is ignored.
  - sw: 2 cycles, asserted while in RESP.
  - sb/sh: 3 cycles, asserted while in RESP.
  - All non-error responses have resp_err = 0.
- resp_rdata and resp_err hold their value until the next response. resp_valid is the qualifier.
- Back-to-back: the earliest next acceptance is the cycle after resp_valid, once back in IDLE.
- req_valid held high while busy is ignored and must remain stable until req_ready is seen.

Decomposition:
- Shared package:
  - size codes SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - state encodings IDLE, READ, MERGE, WRITE, RESP, ERR;
  - alignment-check function.
- One combinational sub-module dm_lane:
  - inputs: word, addr[1:0], size, sign, wdata;
  - outputs: extracted/extended load data and merged store word.
- The RAM array, FSM and response registers live in dm_port.

Test Plan:
1. Word round trip: sw addr 0x10, wdata 0xDEADBEEF, gives resp_valid 2 cycles after acceptance with err 0 and rdata 0. A following lw 0x10 gives rdata 0xDEADBEEF 2 cycles after acceptance.
2. Sub-word loads from word 0x10 = 0xDEADBEEF:
   - lb 0x13 -> 0xFFFFFFDE;
   - lbu 0x13 -> 0x000000DE;
   - lh 0x12 -> 0xFFFFDEAD;
   - lhu 0x10 -> 0x0000BEEF;
   - lb 0x10 -> 0xFFFFFFEF.
3. Sub-word stores:
   - sb 0x11, wdata 0x12345655, gives resp_valid 3 cycles after acceptance; then lw 0x10 -> 0xDEAD55EF.
   - sh 0x12, wdata 0x0000CAFE; then lw 0x10 -> 0xCAFE55EF.
4. Errors:
   - lw 0x12 -> resp_valid 1 cycle after acceptance, err 1, rdata 0;
   - sh 0x13, wdata 0xFFFF -> err 1; lw 0x10 unchanged;
   - size 3 -> err 1.
5. Handshake and wrap-around:
   - req_valid held high across a sb: req_ready is 0 from the acceptance edge until the cycle after resp_valid, and the second request is accepted exactly then.
   - sw at (2**ADDR_W)*4 + 0x10 overwrites word 0x10.
6. Reset mid-operation: rst low in the MERGE cycle of sb 0x10, wdata 0xAA. No resp_valid follows, req_ready = 1 the next cycle, and lw 0x10 returns the prior value.
